// File: rtl/bmp_gray_binarize_if.sv
// Handshake and ROM/RAM byte bus between the BMP converter and its environment.
// The converter uses the master view; the environment/testbench uses the slave view.
interface bmp_gray_binarize_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 20
);
    logic                  in_valid;
    logic                  mode;
    logic [BYTE_WIDTH-1:0] threshold;
    logic [BYTE_WIDTH-1:0] ROM_out;
    logic                  ROM_ren;
    logic [ADDR_WIDTH-1:0] ROM_addr;
    logic                  RAM_ren;
    logic                  RAM_wen;
    logic [BYTE_WIDTH-1:0] RAM_in;
    logic [ADDR_WIDTH-1:0] RAM_addr;
    logic                  done;
    logic                  busy;

    modport master (
        input  in_valid, mode, threshold, ROM_out,
        output ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, done, busy
    );

    modport slave (
        output in_valid, mode, threshold, ROM_out,
        input  ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, done, busy
    );
endinterface

// File: rtl/bmp_gray_binarize.sv
// Streams a BMP from ROM to RAM: header and row padding are copied, each BGR(A)
// pixel becomes weighted luminance (or a thresholded binary value); alpha passes through.
module bmp_gray_binarize #(
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int HEADER_SIZE = 54,
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int CHANNELS    = 3,
    parameter int W_B         = 30,
    parameter int W_G         = 150,
    parameter int W_R         = 76
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bmp_gray_binarize_if.master  bus
);
    localparam int ROW_BYTES = IMG_WIDTH * CHANNELS;
    localparam int PAD       = (4 - ROW_BYTES % 4) % 4;
    localparam int SUM_W     = 2 * BYTE_WIDTH + 2;
    localparam logic [SUM_W-1:0]      GRAY_MAX = SUM_W'((1 << BYTE_WIDTH) - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PIX_RD, S_PIX_CALC, S_PIX_WR, S_PAD, S_FLUSH, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d, col_q, col_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
    logic                  copy_pend_q, copy_pend_d, rd_pend_q, rd_pend_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic                  mode_q, mode_d;
    logic [BYTE_WIDTH-1:0] thr_q, thr_d, result_q, result_d;
    logic [BYTE_WIDTH-1:0] pix_q [0:3];
    logic [BYTE_WIDTH-1:0] pix_d [0:3];
    logic [BYTE_WIDTH-1:0] px_view [0:3];

    logic                  rom_ren, ram_wen;
    logic [SUM_W-1:0]      sum, gray_full;
    logic [BYTE_WIDTH-1:0] gray, result;

    // Pixel buffer as seen this cycle: the byte returning from the previous read
    // overrides its slot, so the last channel is usable in PIX_CALC directly.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_px
            assign px_view[gi] = (rd_pend_q && rd_idx_q == 2'(gi)) ? bus.ROM_out : pix_q[gi];
        end
    endgenerate

    always_comb begin
        sum = SUM_W'(px_view[0]) * SUM_W'(W_B)
            + SUM_W'(px_view[1]) * SUM_W'(W_G)
            + SUM_W'(px_view[2]) * SUM_W'(W_R);
        gray_full = sum >> 8;
        gray      = (gray_full > GRAY_MAX) ? '1 : gray_full[BYTE_WIDTH-1:0];
        result    = mode_q ? ((gray >= thr_q) ? '1 : '0) : gray;
    end

    assign rom_ren = (state_q == S_HDR) || (state_q == S_PIX_RD) || (state_q == S_PAD);
    assign ram_wen = copy_pend_q || (state_q == S_PIX_WR);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        copy_pend_d = 1'b0;
        rd_pend_d   = 1'b0;
        rd_idx_d    = rd_idx_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        result_d    = result_q;
        for (int k = 0; k < 4; k++) pix_d[k] = px_view[k];

        if (rom_ren) rom_addr_d = rom_addr_q + ADDR_ONE;
        if (ram_wen) ram_addr_d = ram_addr_q + ADDR_ONE;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d    = S_HDR;
                    mode_d     = bus.mode;
                    thr_d      = bus.threshold;
                    cnt_d      = '0;
                    col_d      = '0;
                    row_d      = '0;
                    rom_addr_d = '0;
                    ram_addr_d = '0;
                end
            end
            S_HDR: begin
                copy_pend_d = 1'b1;
                if (int'(cnt_q) == HEADER_SIZE - 1) begin
                    cnt_d   = '0;
                    state_d = S_PIX_RD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PIX_RD: begin
                rd_pend_d = 1'b1;
                rd_idx_d  = cnt_q[1:0];
                if (int'(cnt_q) == CHANNELS - 1) begin
                    cnt_d   = '0;
                    state_d = S_PIX_CALC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PIX_CALC: begin
                result_d = result;
                state_d  = S_PIX_WR;
            end
            S_PIX_WR: begin
                if (int'(cnt_q) == CHANNELS - 1) begin
                    cnt_d = '0;
                    if (int'(col_q) == IMG_WIDTH - 1) begin
                        col_d = '0;
                        if (PAD > 0) begin
                            state_d = S_PAD;
                        end else if (int'(row_q) == IMG_HEIGHT - 1) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 16'd1;
                            state_d = S_PIX_RD;
                        end
                    end else begin
                        col_d   = col_q + 16'd1;
                        state_d = S_PIX_RD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PAD: begin
                copy_pend_d = 1'b1;
                if (int'(cnt_q) == PAD - 1) begin
                    cnt_d = '0;
                    if (int'(row_q) == IMG_HEIGHT - 1) begin
                        state_d = S_FLUSH;
                    end else begin
                        row_d   = row_q + 16'd1;
                        state_d = S_PIX_RD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE: begin
                state_d    = S_IDLE;
                rom_addr_d = '0;
                ram_addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            copy_pend_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            mode_q      <= 1'b0;
            thr_q       <= '0;
            result_q    <= '0;
            for (int k = 0; k < 4; k++) pix_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            copy_pend_q <= copy_pend_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            result_q    <= result_d;
            for (int k = 0; k < 4; k++) pix_q[k] <= pix_d[k];
        end
    end

    // Copy bytes forward the ROM data in the cycle it arrives; pixel bytes come from registers.
    assign bus.ROM_ren  = rom_ren;
    assign bus.ROM_addr = rom_addr_q;
    assign bus.RAM_ren  = 1'b0;
    assign bus.RAM_wen  = ram_wen;
    assign bus.RAM_in   = copy_pend_q ? bus.ROM_out
                        : ((CHANNELS == 4 && cnt_q[1:0] == 2'd3) ? pix_q[3] : result_q);
    assign bus.RAM_addr = ram_addr_q;
    assign bus.done     = (state_q == S_DONE);
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_bmp_gray_binarize.sv
// Bench for bmp_gray_binarize: two 2x2 instances (BGR with padding, BGRA without),
// randomized images checked byte-by-byte against a reference model of the conversion.
module tb_bmp_gray_binarize;
    localparam int BW = 8, AW = 20, HDR = 54, TOT = 70;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bmp_gray_binarize_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus3 ();
    bmp_gray_binarize_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus4 ();

    bmp_gray_binarize #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.master));
    bmp_gray_binarize #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.master));

    logic [7:0] rom [0:1][0:127];
    logic [7:0] ram [0:1][0:127];
    int rd_cyc [0:1][0:127];
    int wr_cyc [0:1][0:127];
    int wr_cnt, done_k;
    int n_vec = 0, n_err = 0;
    logic [7:0] rom_q3, rom_q4;

    // Synchronous ROMs: data is valid the cycle after the read enable.
    always @(posedge clk) if (bus3.ROM_ren) rom_q3 <= rom[0][bus3.ROM_addr[6:0]];
    always @(posedge clk) if (bus4.ROM_ren) rom_q4 <= rom[1][bus4.ROM_addr[6:0]];
    assign bus3.ROM_out = rom_q3;
    assign bus4.ROM_out = rom_q4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int n_ch(input int id);
        return (id == 0) ? 3 : 4;
    endfunction

    function automatic int pad_of(input int id);
        return (4 - (2 * n_ch(id)) % 4) % 4;
    endfunction

    function automatic bit is_copy(input int id, input int a);
        int stride = 2 * n_ch(id) + pad_of(id);
        if (a < HDR) return 1'b1;
        return ((a - HDR) % stride) >= 2 * n_ch(id);
    endfunction

    // Reference: luminance from the pixel the byte belongs to, alpha and copies verbatim.
    function automatic logic [7:0] exp_byte(input int id, input bit m, input logic [7:0] thr, input int a);
        int c = n_ch(id);
        int stride = 2 * c + pad_of(id);
        int ch, base, g;
        if (is_copy(id, a)) return rom[id][a];
        ch = ((a - HDR) % stride) % c;
        if (ch == 3) return rom[id][a];
        base = a - ch;
        g = (rom[id][base] * 30 + rom[id][base + 1] * 150 + rom[id][base + 2] * 76) / 256;
        if (g > 255) g = 255;
        if (m) return (g >= int'(thr)) ? 8'hFF : 8'h00;
        return g[7:0];
    endfunction

    task automatic drive(input int id, input bit iv, input bit m, input logic [7:0] thr);
        if (id == 0) begin
            bus3.in_valid = iv; bus3.mode = m; bus3.threshold = thr;
        end else begin
            bus4.in_valid = iv; bus4.mode = m; bus4.threshold = thr;
        end
    endtask

    task automatic fill(input int id, input bit hdr_index);
        for (int a = 0; a < 128; a++)
            rom[id][a] = (hdr_index && a < HDR) ? 8'(a) : 8'($urandom_range(0, 255));
        rom[id][54] = 8'd10; rom[id][55] = 8'd20; rom[id][56] = 8'd30;
        if (id == 0) begin
            rom[0][57] = 8'd255; rom[0][58] = 8'd255; rom[0][59] = 8'd255;
            rom[0][60] = 8'hAA; rom[0][61] = 8'hAA; rom[0][68] = 8'hAA; rom[0][69] = 8'hAA;
        end else begin
            rom[1][57] = 8'h7F;
        end
    endtask

    // One run: pulse in_valid, then log every read/write per cycle until done.
    task automatic run(input int id, input bit m, input logic [7:0] thr, input bit poke,
                       input int abort_at, output bit aborted);
        int k;
        bit got;
        logic ren, wen, rren, dn;
        logic [AW-1:0] ra, wa;
        logic [7:0] wd;
        for (int a = 0; a < 128; a++) begin
            ram[id][a] = 8'hxx; rd_cyc[id][a] = -1; wr_cyc[id][a] = -1;
        end
        wr_cnt = 0; done_k = -1; got = 1'b0; aborted = 1'b0; k = 0;
        @(negedge clk);
        drive(id, 1'b1, m, thr);
        while (k < 400 && !got && !aborted) begin
            @(negedge clk);
            k++;
            if (k == 1) drive(id, 1'b0, m, thr);
            if (poke && k == 10) drive(id, 1'b1, ~m, ~thr);
            if (poke && k == 11) drive(id, 1'b0, m, thr);
            if (id == 0) begin
                ren = bus3.ROM_ren; ra = bus3.ROM_addr; wen = bus3.RAM_wen; wa = bus3.RAM_addr;
                wd = bus3.RAM_in; rren = bus3.RAM_ren; dn = bus3.done;
            end else begin
                ren = bus4.ROM_ren; ra = bus4.ROM_addr; wen = bus4.RAM_wen; wa = bus4.RAM_addr;
                wd = bus4.RAM_in; rren = bus4.RAM_ren; dn = bus4.done;
            end
            if (ren && ra < 128) rd_cyc[id][ra[6:0]] = k;
            if (wen) begin
                chk($sformatf("wr_order[%0d]", wr_cnt), 32'(wa), wr_cnt);
                chk("ram_ren", 32'(rren), 0);
                if (wa < 128) begin
                    ram[id][wa[6:0]] = wd;
                    wr_cyc[id][wa[6:0]] = k;
                end
                wr_cnt++;
            end
            if (dn) begin
                done_k = k; got = 1'b1;
            end
            if (abort_at > 0 && wr_cnt == abort_at) begin
                rst_n = 1'b0; aborted = 1'b1;
            end
        end
        if (!aborted) chk("done_seen", 32'(got), 1);
    endtask

    task automatic verify(input int id, input bit m, input logic [7:0] thr);
        int cost = HDR + 4 * (2 * n_ch(id) + 1) + 2 * pad_of(id) + ((pad_of(id) > 0) ? 1 : 0);
        chk("wr_count", wr_cnt, TOT);
        chk("done_latency", done_k, cost + 1);
        chk("done_after_last_wr", done_k, wr_cyc[id][TOT - 1] + 1);
        chk("first_rd_cycle", rd_cyc[id][0], 1);
        for (int a = 0; a < TOT; a++) begin
            chk($sformatf("ram[%0d]", a), 32'(ram[id][a]), 32'(exp_byte(id, m, thr, a)));
            if (is_copy(id, a)) chk($sformatf("copy_lag[%0d]", a), wr_cyc[id][a], rd_cyc[id][a] + 1);
        end
        @(negedge clk);
        chk("busy_after_done", 32'(id == 0 ? bus3.busy : bus4.busy), 0);
    endtask

    initial begin
        bit ab;
        logic [7:0] thr;
        drive(0, 1'b0, 1'b0, 8'd0);
        drive(1, 1'b0, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        chk("rst_rom_ren", 32'(bus3.ROM_ren), 0);
        chk("rst_rom_addr", 32'(bus3.ROM_addr), 0);
        chk("rst_ram_wen", 32'(bus3.RAM_wen), 0);
        chk("rst_ram_ren", 32'(bus3.RAM_ren), 0);
        chk("rst_ram_in", 32'(bus3.RAM_in), 0);
        chk("rst_ram_addr", 32'(bus3.RAM_addr), 0);
        chk("rst_done", 32'(bus3.done), 0);
        chk("rst_busy", 32'(bus3.busy), 0);
        chk("rst_busy4", 32'(bus4.busy), 0);
        rst_n = 1'b1;

        fill(0, 1'b1);
        run(0, 1'b0, 8'd0, 1'b0, 0, ab);
        verify(0, 1'b0, 8'd0);
        chk("gray_b", 32'(ram[0][54]), 21);
        chk("gray_r", 32'(ram[0][56]), 21);
        chk("gray_sat", 32'(ram[0][57]), 255);
        chk("pad_60", 32'(ram[0][60]), 32'h00AA);
        chk("pad_69", 32'(ram[0][69]), 32'h00AA);

        fill(0, 1'b0);
        run(0, 1'b1, 8'd21, 1'b1, 0, ab);
        verify(0, 1'b1, 8'd21);
        chk("bin_thr21", 32'(ram[0][55]), 255);
        run(0, 1'b1, 8'd22, 1'b0, 0, ab);
        verify(0, 1'b1, 8'd22);
        chk("bin_thr22", 32'(ram[0][55]), 0);

        fill(1, 1'b0);
        run(1, 1'b0, 8'd0, 1'b0, 0, ab);
        verify(1, 1'b0, 8'd0);
        chk("bgra_g", 32'(ram[1][55]), 21);
        chk("bgra_alpha", 32'(ram[1][57]), 32'h007F);

        for (int it = 0; it < 3; it++) begin
            thr = 8'($urandom_range(0, 255));
            fill(it % 2, 1'b0);
            run(it % 2, 1'($urandom_range(0, 1)), thr, 1'b1, 0, ab);
            verify(it % 2, bus3.mode & (it % 2 == 0) | bus4.mode & (it % 2 == 1), thr);
        end

        fill(0, 1'b0);
        run(0, 1'b0, 8'd0, 1'b0, 55, ab);
        chk("abort_reached", 32'(ab), 1);
        #1;
        chk("abort_rom_ren", 32'(bus3.ROM_ren), 0);
        chk("abort_ram_wen", 32'(bus3.RAM_wen), 0);
        chk("abort_busy", 32'(bus3.busy), 0);
        chk("abort_ram_addr", 32'(bus3.RAM_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 1'b0, 8'd0, 1'b0, 0, ab);
        verify(0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
